// File: rtl/arb_grant_xfer_ctrl.sv
// arb_grant_xfer_ctrl: routes the granted client's stream to a shared sink.
// Caps each ownership at MAX_BEATS beats, pulses done, flags multi-hot grants.
module arb_grant_xfer_ctrl #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gnt0,
  input  logic              gnt1,
  input  logic              gnt2,
  input  logic              gnt3,
  input  logic              vld0,
  input  logic              vld1,
  input  logic              vld2,
  input  logic              vld3,
  input  logic [DATA_W-1:0] dat0,
  input  logic [DATA_W-1:0] dat1,
  input  logic [DATA_W-1:0] dat2,
  input  logic [DATA_W-1:0] dat3,
  output logic              rdy0,
  output logic              rdy1,
  output logic              rdy2,
  output logic              rdy3,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat,
  input  logic              out_rdy,
  output logic [1:0]        owner,
  output logic              busy,
  output logic              done0,
  output logic              done1,
  output logic              done2,
  output logic              done3,
  output logic              err_multi
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BEATS - 1);

  state_t state;
  state_t state_nxt;

  logic [3:0]        gnt;
  logic [3:0]        vld;
  logic [DATA_W-1:0] dat [4];
  logic [3:0]        rdy;
  logic [3:0]        done_q;

  logic [1:0]        owner_q;
  logic [CNT_W-1:0]  beat_cnt;
  logic              busy_q;
  logic              err_q;

  logic              gnt_multi;
  logic              gnt_one;
  logic [1:0]        gnt_idx;
  logic              own_gnt;
  logic              own_vld;
  logic              accept;
  logic              last;

  assign gnt    = {gnt3, gnt2, gnt1, gnt0};
  assign vld    = {vld3, vld2, vld1, vld0};
  assign dat[0] = dat0;
  assign dat[1] = dat1;
  assign dat[2] = dat2;
  assign dat[3] = dat3;

  assign rdy0 = rdy[0];
  assign rdy1 = rdy[1];
  assign rdy2 = rdy[2];
  assign rdy3 = rdy[3];

  assign done0 = done_q[0];
  assign done1 = done_q[1];
  assign done2 = done_q[2];
  assign done3 = done_q[3];

  assign owner     = owner_q;
  assign busy      = busy_q;
  assign err_multi = err_q;

  // Grant decode: clearing the lowest set bit leaves a residue only if multi-hot.
  always_comb begin
    gnt_multi = |(gnt & (gnt - 4'd1));
    gnt_one   = (gnt != 4'd0) && !gnt_multi;
    gnt_idx   = 2'd0;
    case (gnt)
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
  end

  assign own_gnt = gnt[owner_q];
  assign own_vld = vld[owner_q];
  assign accept  = (state == XFER) && own_vld && out_rdy;
  assign last    = accept && (beat_cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; a dropped grant wins over reaching the beat cap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt_one) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (!own_gnt) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!own_gnt) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sink mux: only the owner is connected, and only while transferring.
  always_comb begin
    out_vld = 1'b0;
    out_dat = '0;
    rdy     = 4'b0000;
    if (state == XFER) begin
      out_vld      = own_vld;
      out_dat      = dat[owner_q];
      rdy[owner_q] = out_rdy;
    end
  end

  // Owner latch, beat counter, busy, done pulse and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= 2'd0;
      beat_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 4'b0000;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && gnt_one) begin
        owner_q <= gnt_idx;
      end
      if (state_nxt != XFER) begin
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      busy_q <= (state_nxt != IDLE);
      done_q <= last ? (4'b0001 << owner_q) : 4'b0000;
      err_q  <= err_q | gnt_multi;
    end
  end

endmodule
